// File: rtl/hdmi_data_decoder_pkg.sv
// Shared HDMI data-island constants and the BCH parity step used by encoder and decoder.
package hdmi_data_decoder_pkg;

  localparam int          HDMI_PKT_CLKS      = 32;
  localparam int          HDMI_HDR_BITS      = 24;
  localparam int          HDMI_SUB_BITS      = 56;
  localparam int          HDMI_PAR_BITS      = 8;
  localparam logic [7:0]  HDMI_BCH_POLY      = 8'hC1;
  localparam int          HDMI_PREAMBLE_CLKS = 8;
  localparam int          HDMI_GUARD_CLKS    = 2;

  typedef logic [HDMI_PAR_BITS-1:0] parity_t;

  // One received bit through the BCH(64,56)/(32,24) parity LFSR.
  function automatic parity_t bch_step(input parity_t state, input logic bit_in);
    return {state[HDMI_PAR_BITS-2:0], 1'b0} ^ ((state[HDMI_PAR_BITS-1] ^ bit_in) ? HDMI_BCH_POLY : '0);
  endfunction

endpackage

// File: rtl/hdmi_data_decoder_bch.sv
// BCH parity checker: runs the LFSR over data bits, collects received parity, flags mismatch.
module hdmi_data_decoder_bch
  import hdmi_data_decoder_pkg::*;
#(
  parameter int BITS = 1
) (
  input  logic            i_pixclk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic            i_data_en,
  input  logic            i_par_en,
  input  logic [BITS-1:0] i_bits,
  output logic            o_mismatch
);

  parity_t r_state;
  parity_t r_par;
  parity_t w_state;
  parity_t w_par;

  // Bit 0 of i_bits is the first one transmitted, both for data and for parity pairs.
  always_comb begin
    w_state = i_start ? '0 : r_state;
    w_par   = r_par;
    for (int i = 0; i < BITS; i++) begin
      if (i_data_en) w_state = bch_step(w_state, i_bits[i]);
      if (i_par_en)  w_par   = {w_par[HDMI_PAR_BITS-2:0], i_bits[i]};
    end
  end

  assign o_mismatch = (w_par != w_state);

  always_ff @(posedge i_pixclk) begin
    if (!i_rst_n) begin
      r_state <= '0;
      r_par   <= '0;
    end else begin
      if (i_data_en) r_state <= w_state;
      if (i_par_en)  r_par   <= w_par;
    end
  end

endmodule

// File: rtl/hdmi_data_decoder.sv
// HDMI data-island packet decoder: reassembles header/subpackets from TERC4 nibbles and checks BCH parity.
module hdmi_data_decoder
  import hdmi_data_decoder_pkg::*;
#(
  parameter int PKT_CLKS = HDMI_PKT_CLKS
) (
  input  logic                     i_pixclk,
  input  logic                     i_rst_n,
  input  logic                     i_data,
  input  logic [3:0]               i_d0,
  input  logic [3:0]               i_d1,
  input  logic [3:0]               i_d2,
  output logic                     o_valid,
  output logic [HDMI_HDR_BITS-1:0] o_header,
  output logic [HDMI_SUB_BITS-1:0] o_sub0,
  output logic [HDMI_SUB_BITS-1:0] o_sub1,
  output logic [HDMI_SUB_BITS-1:0] o_sub2,
  output logic [HDMI_SUB_BITS-1:0] o_sub3,
  output logic                     o_hdr_err,
  output logic [3:0]               o_sub_err,
  output logic                     o_frame_err,
  output logic                     o_trunc,
  output logic                     o_hsync,
  output logic                     o_vsync
);

  localparam int               POS_W    = $clog2(PKT_CLKS);
  localparam logic [POS_W-1:0] LAST_POS = POS_W'(PKT_CLKS - 1);
  localparam logic [POS_W-1:0] HDR_END  = POS_W'(HDMI_HDR_BITS);
  localparam logic [POS_W-1:0] SUB_END  = POS_W'(HDMI_SUB_BITS / 2);

  logic [POS_W-1:0]                r_pos;
  logic                            r_armed;
  logic                            r_first;
  logic                            r_frame_acc;
  logic [HDMI_HDR_BITS-1:0]        r_hdr;
  logic [3:0][HDMI_SUB_BITS-1:0]   r_sub;

  logic       w_active;
  logic       w_start;
  logic       w_last;
  logic       w_hdr_data;
  logic       w_hdr_par;
  logic       w_sub_data;
  logic       w_sub_par;
  logic       w_flag_bad;
  logic       w_frame_next;
  logic       w_hdr_mis;
  logic [3:0] w_sub_mis;

  // r_armed stays low after a reset until i_data is seen low, so a half-received island is ignored.
  assign w_active     = i_data & r_armed;
  assign w_start      = w_active & (r_pos == '0);
  assign w_last       = w_active & (r_pos == LAST_POS);
  assign w_hdr_data   = w_active & (r_pos < HDR_END);
  assign w_hdr_par    = w_active & (r_pos >= HDR_END);
  assign w_sub_data   = w_active & (r_pos < SUB_END);
  assign w_sub_par    = w_active & (r_pos >= SUB_END);
  assign w_flag_bad   = (w_start & r_first) ? i_d0[3] : ~i_d0[3];
  assign w_frame_next = (w_start ? 1'b0 : r_frame_acc) | w_flag_bad;

  hdmi_data_decoder_bch #(.BITS(1)) u_hdr_bch (
    .i_pixclk  (i_pixclk),
    .i_rst_n   (i_rst_n),
    .i_start   (w_start),
    .i_data_en (w_hdr_data),
    .i_par_en  (w_hdr_par),
    .i_bits    (i_d0[2]),
    .o_mismatch(w_hdr_mis)
  );

  for (genvar k = 0; k < 4; k++) begin : g_sub_bch
    hdmi_data_decoder_bch #(.BITS(2)) u_sub_bch (
      .i_pixclk  (i_pixclk),
      .i_rst_n   (i_rst_n),
      .i_start   (w_start),
      .i_data_en (w_sub_data),
      .i_par_en  (w_sub_par),
      .i_bits    ({i_d2[k], i_d1[k]}),
      .o_mismatch(w_sub_mis[k])
    );
  end

  always_ff @(posedge i_pixclk) begin
    if (!i_rst_n) begin
      r_pos       <= '0;
      r_armed     <= 1'b0;
      r_first     <= 1'b1;
      r_frame_acc <= 1'b0;
      r_hdr       <= '0;
      r_sub       <= '0;
      o_valid     <= 1'b0;
      o_header    <= '0;
      o_sub0      <= '0;
      o_sub1      <= '0;
      o_sub2      <= '0;
      o_sub3      <= '0;
      o_hdr_err   <= 1'b0;
      o_sub_err   <= '0;
      o_frame_err <= 1'b0;
      o_trunc     <= 1'b0;
      o_hsync     <= 1'b0;
      o_vsync     <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      o_trunc <= 1'b0;
      if (i_data) begin
        o_hsync <= i_d0[0];
        o_vsync <= i_d0[1];
      end
      if (!i_data) begin
        r_armed <= 1'b1;
        r_first <= 1'b1;
        r_pos   <= '0;
        if (r_pos != '0) o_trunc <= 1'b1;
      end else if (r_armed) begin
        r_pos       <= w_last ? '0 : r_pos + 1'b1;
        r_frame_acc <= w_frame_next;
        if (w_hdr_data) r_hdr <= {i_d0[2], r_hdr[HDMI_HDR_BITS-1:1]};
        for (int k = 0; k < 4; k++) begin
          if (w_sub_data) r_sub[k] <= {i_d2[k], i_d1[k], r_sub[k][HDMI_SUB_BITS-1:2]};
        end
        // Final nibble: publish the packet together with parity verdicts that include it.
        if (w_last) begin
          o_valid     <= 1'b1;
          o_header    <= r_hdr;
          o_sub0      <= r_sub[0];
          o_sub1      <= r_sub[1];
          o_sub2      <= r_sub[2];
          o_sub3      <= r_sub[3];
          o_hdr_err   <= w_hdr_mis;
          o_sub_err   <= w_sub_mis;
          o_frame_err <= w_frame_next;
          r_first     <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_hdmi_data_decoder.sv
// Directed bench for hdmi_data_decoder: packets are encoded here and decoded results asserted.
module tb_hdmi_data_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        data;
  logic [3:0]  d0, d1, d2;
  logic        o_valid, o_hdr_err, o_frame_err, o_trunc, o_hsync, o_vsync;
  logic [23:0] o_header;
  logic [55:0] o_sub0, o_sub1, o_sub2, o_sub3;
  logic [3:0]  o_sub_err;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int vCount = 0;
  int tCount = 0;
  int startCyc, vBase, tBase;

  int          vCyc[16];
  logic [23:0] vHdr[16];
  logic [55:0] vSub0[16];
  logic        vHdrErr[16];
  logic [3:0]  vSubErr[16];
  logic        vFrameErr[16];

  logic [3:0] tD0[32];
  logic [3:0] tD1[32];
  logic [3:0] tD2[32];

  localparam logic [23:0] ACR_HDR = 24'h000001;
  localparam logic [55:0] ACR_SUB = 56'h00180078690000;
  localparam logic [23:0] AVI_HDR = 24'h0D0282;
  localparam logic [55:0] AVI_SUB = 56'h00000000191046;
  localparam logic [23:0] AUD_HDR = 24'h0A0184;
  localparam logic [55:0] AUD_SUB = 56'h00000000001160;

  hdmi_data_decoder dut (
    .i_pixclk   (clk),
    .i_rst_n    (rst_n),
    .i_data     (data),
    .i_d0       (d0),
    .i_d1       (d1),
    .i_d2       (d2),
    .o_valid    (o_valid),
    .o_header   (o_header),
    .o_sub0     (o_sub0),
    .o_sub1     (o_sub1),
    .o_sub2     (o_sub2),
    .o_sub3     (o_sub3),
    .o_hdr_err  (o_hdr_err),
    .o_sub_err  (o_sub_err),
    .o_frame_err(o_frame_err),
    .o_trunc    (o_trunc),
    .o_hsync    (o_hsync),
    .o_vsync    (o_vsync)
  );

  always #5 clk = ~clk;

  // Log every strobe shortly after the edge that produced it.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (o_valid) begin
      if (vCount < 16) begin
        vCyc[vCount]      = cyc;
        vHdr[vCount]      = o_header;
        vSub0[vCount]     = o_sub0;
        vHdrErr[vCount]   = o_hdr_err;
        vSubErr[vCount]   = o_sub_err;
        vFrameErr[vCount] = o_frame_err;
      end
      vCount++;
    end
    if (o_trunc) tCount++;
  end

  function automatic logic [7:0] parStep(input logic [7:0] s, input logic b);
    return {s[6:0], 1'b0} ^ ((s[7] ^ b) ? 8'hC1 : 8'h00);
  endfunction

  task automatic buildPacket(input logic [23:0] hdr, input logic [55:0] sub, input bit firstOfIsland);
    logic [7:0] hp;
    logic [7:0] sp;
    hp = 8'h00;
    for (int p = 0; p < 32; p++) begin
      tD0[p][0] = (p % 2 == 1);
      tD0[p][1] = 1'b1;
      tD0[p][3] = (firstOfIsland && p == 0) ? 1'b0 : 1'b1;
      if (p < 24) begin
        tD0[p][2] = hdr[p];
        hp = parStep(hp, hdr[p]);
      end
    end
    for (int p = 24; p < 32; p++) tD0[p][2] = hp[31 - p];
    for (int k = 0; k < 4; k++) begin
      sp = 8'h00;
      for (int p = 0; p < 28; p++) begin
        tD1[p][k] = sub[2*p];
        tD2[p][k] = sub[2*p+1];
        sp = parStep(parStep(sp, sub[2*p]), sub[2*p+1]);
      end
      for (int p = 28; p < 32; p++) begin
        tD1[p][k] = sp[7 - 2*(p-28)];
        tD2[p][k] = sp[6 - 2*(p-28)];
      end
    end
  endtask

  task automatic applyStimulus(input int firstPos, input int lastPos);
    for (int p = firstPos; p <= lastPos; p++) begin
      data = 1'b1;
      d0 = tD0[p];
      d1 = tD1[p];
      d2 = tD2[p];
      @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      data = 1'b0;
      d0 = 4'h0;
      d1 = 4'h0;
      d2 = 4'h0;
      @(negedge clk);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    rst_n = 1'b0;
    data = 1'b0;
    d0 = 4'h0;
    d1 = 4'h0;
    d2 = 4'h0;
    repeat (3) @(negedge clk);
    checkOutput("rst_valid", o_valid, 0);
    checkOutput("rst_header", o_header, 0);
    checkOutput("rst_sub0", o_sub0, 0);
    checkOutput("rst_errs", {o_hdr_err, o_sub_err, o_frame_err, o_trunc}, 0);
    checkOutput("rst_sync", {o_hsync, o_vsync}, 0);
    rst_n = 1'b1;
    idle(2);

    $display("[TB] ACR packet");
    buildPacket(ACR_HDR, ACR_SUB, 1'b1);
    vBase = vCount;
    startCyc = cyc;
    applyStimulus(0, 31);
    checkOutput("acr_valid", o_valid, 1);
    checkOutput("acr_count", vCount, vBase + 1);
    checkOutput("acr_latency", vCyc[vBase], startCyc + 32);
    checkOutput("acr_header", o_header, ACR_HDR);
    checkOutput("acr_sub0", o_sub0, ACR_SUB);
    checkOutput("acr_sub3", o_sub3, ACR_SUB);
    checkOutput("acr_errs", {o_hdr_err, o_sub_err, o_frame_err}, 0);
    checkOutput("acr_sync", {o_hsync, o_vsync}, 2'b11);
    idle(1);
    checkOutput("acr_strobe_end", o_valid, 0);
    checkOutput("acr_hold_hdr", o_header, ACR_HDR);
    idle(2);
    checkOutput("acr_sync_hold", {o_hsync, o_vsync}, 2'b11);

    $display("[TB] AVI then audio infoframe back-to-back");
    vBase = vCount;
    startCyc = cyc;
    buildPacket(AVI_HDR, AVI_SUB, 1'b1);
    applyStimulus(0, 31);
    buildPacket(AUD_HDR, AUD_SUB, 1'b0);
    applyStimulus(0, 31);
    idle(2);
    checkOutput("b2b_count", vCount, vBase + 2);
    checkOutput("b2b_cyc0", vCyc[vBase], startCyc + 32);
    checkOutput("b2b_cyc1", vCyc[vBase+1], startCyc + 64);
    checkOutput("b2b_hdr0", vHdr[vBase], AVI_HDR);
    checkOutput("b2b_sub0_0", vSub0[vBase], AVI_SUB);
    checkOutput("b2b_hdr1", vHdr[vBase+1], AUD_HDR);
    checkOutput("b2b_sub0_1", vSub0[vBase+1], AUD_SUB);
    checkOutput("b2b_errs0", {vHdrErr[vBase], vSubErr[vBase], vFrameErr[vBase]}, 0);
    checkOutput("b2b_errs1", {vHdrErr[vBase+1], vSubErr[vBase+1], vFrameErr[vBase+1]}, 0);

    $display("[TB] header bit 5 corrupted");
    buildPacket(ACR_HDR, ACR_SUB, 1'b1);
    tD0[5][2] = ~tD0[5][2];
    applyStimulus(0, 31);
    checkOutput("hflip_valid", o_valid, 1);
    checkOutput("hflip_hdr_err", o_hdr_err, 1);
    checkOutput("hflip_sub_err", o_sub_err, 4'b0000);
    checkOutput("hflip_header", o_header, 24'h000021);
    idle(2);

    $display("[TB] subpacket 2 odd bit corrupted at position 10");
    buildPacket(ACR_HDR, ACR_SUB, 1'b1);
    tD2[10][2] = ~tD2[10][2];
    applyStimulus(0, 31);
    checkOutput("sflip_valid", o_valid, 1);
    checkOutput("sflip_sub_err", o_sub_err, 4'b0100);
    checkOutput("sflip_hdr_err", o_hdr_err, 0);
    checkOutput("sflip_sub2", o_sub2, ACR_SUB ^ (56'h1 << 21));
    checkOutput("sflip_sub1", o_sub1, ACR_SUB);
    idle(2);

    $display("[TB] island dropped after position 19");
    buildPacket(ACR_HDR, ACR_SUB, 1'b1);
    vBase = vCount;
    tBase = tCount;
    applyStimulus(0, 19);
    idle(1);
    checkOutput("trunc_pulse", o_trunc, 1);
    idle(1);
    checkOutput("trunc_end", o_trunc, 0);
    checkOutput("trunc_count", tCount, tBase + 1);
    checkOutput("trunc_no_valid", vCount, vBase);
    buildPacket(AVI_HDR, AVI_SUB, 1'b1);
    applyStimulus(0, 31);
    checkOutput("after_trunc_valid", o_valid, 1);
    checkOutput("after_trunc_hdr", o_header, AVI_HDR);
    checkOutput("after_trunc_sub0", o_sub0, AVI_SUB);
    checkOutput("after_trunc_errs", {o_hdr_err, o_sub_err, o_frame_err}, 0);
    idle(2);

    $display("[TB] start flag high on island clock 0");
    buildPacket(ACR_HDR, ACR_SUB, 1'b1);
    tD0[0][3] = 1'b1;
    applyStimulus(0, 31);
    checkOutput("frame_valid", o_valid, 1);
    checkOutput("frame_err", o_frame_err, 1);
    checkOutput("frame_header", o_header, ACR_HDR);
    checkOutput("frame_sub0", o_sub0, ACR_SUB);
    checkOutput("frame_bch", {o_hdr_err, o_sub_err}, 0);
    idle(2);

    $display("[TB] reset pulse at position 15");
    buildPacket(ACR_HDR, ACR_SUB, 1'b1);
    vBase = vCount;
    tBase = tCount;
    applyStimulus(0, 14);
    rst_n = 1'b0;
    data = 1'b1;
    d0 = tD0[15];
    d1 = tD1[15];
    d2 = tD2[15];
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("mrst_header", o_header, 0);
    checkOutput("mrst_subs", {o_sub0, o_sub3}, 0);
    checkOutput("mrst_flags", {o_valid, o_hdr_err, o_sub_err, o_frame_err, o_trunc}, 0);
    checkOutput("mrst_sync", {o_hsync, o_vsync}, 0);
    applyStimulus(16, 31);
    idle(3);
    checkOutput("mrst_no_valid", vCount, vBase);
    checkOutput("mrst_no_trunc", tCount, tBase);
    buildPacket(AUD_HDR, AUD_SUB, 1'b1);
    applyStimulus(0, 31);
    checkOutput("after_rst_valid", o_valid, 1);
    checkOutput("after_rst_hdr", o_header, AUD_HDR);
    checkOutput("after_rst_sub0", o_sub0, AUD_SUB);
    checkOutput("after_rst_errs", {o_hdr_err, o_sub_err, o_frame_err}, 0);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hdmi_data_decoder.md
HDMI_DATA_DECODER -- requirements
Module: hdmidatadecoder

Interface
REQ-001 SHALL take parameter PKT_CLKS, default 32, meaning pixel clocks per data-island packet.
REQ-002 SHALL have port i_pixclk  in  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port i_rst_n  in  1  reset, synchronous, active-low.
REQ-004 SHALL have port i_data  in  1  high while the TERC4-decoded data-island period is in progress.
REQ-005 SHALL have port i_d0  in  4  channel-0 nibble: bit0 hsync, bit1 vsync, bit2 header bit, bit3 packet-start flag (low only on island clock 0).
REQ-006 SHALL have ports i_d1 and i_d2  in  4 each  subpacket k: even bit on i_d1[k], odd bit on i_d2[k].
REQ-007 SHALL have port o_valid  out  1  one-cycle strobe, complete packet on outputs.
REQ-008 SHALL have ports o_header  out  24  and o_sub0..o_sub3  out  56 each  packet payload, LSB first as transmitted.
REQ-009 SHALL have ports o_hdr_err  out  1  and o_sub_err  out  4  BCH mismatch flags, valid with o_valid.
REQ-010 SHALL have port o_frame_err  out  1  start-flag violation, valid with o_valid.
REQ-011 SHALL have port o_trunc  out  1  one-cycle strobe, island ended mid-packet.
REQ-012 SHALL have ports o_hsync and o_vsync  out  1 each  i_d0[0] and i_d0[1], registered, updated only while i_data=1.

Function
REQ-013 SHALL keep a 5-bit position counter: cleared when i_data=0; increments on each i_data=1 clock; wraps 31->0, so back-to-back packets are accepted.
REQ-014 SHALL, at position p<24, shift i_d0[2] into header bit p; at positions 24..31, capture received header parity MSB first, i.e. bit 7 at position 24.
REQ-015 SHALL, at position p<28, store subpacket k bits 2p (i_d1[k]) and 2p+1 (i_d2[k]); at positions 28..31, capture parity pairs: i_d1[k] is the higher bit and i_d2[k] the next, starting with bits 7,6.
REQ-016 SHALL compute BCH(64,56)/(32,24) parity per received data bit with the LFSR state update state=(state<<1)^((state[7]^bit)?8'hC1:0); initial state 0; subpackets apply even bit then odd bit in one clock.
REQ-017 SHALL set o_hdr_err or o_sub_err[k] when the computed parity differs from the received parity; payload is output unmodified, with no correction.
REQ-018 SHALL set o_frame_err when i_d0[3]=1 at position 0 of the first packet of an island, or i_d0[3]=0 at any other position.
REQ-019 SHALL pulse o_valid the clock after the position-31 nibble is sampled, i.e. latency 1 from the last input clock; for back-to-back packets o_valid strobes are 32 clocks apart.
REQ-020 SHALL hold o_header, o_sub*, and the error flags until the next o_valid.
REQ-021 SHALL, if i_data falls with position !=0, discard the partial packet, pulse o_trunc the next clock, and not pulse o_valid.
REQ-022 SHALL, if i_data rises in the same clock as a completing o_valid, start the new packet at position 0 without loss.
REQ-023 SHALL reset the LFSR state to 0 at position 0 of every packet.

Reset
REQ-024 SHALL, while i_rst_n=0 at a clock edge, clear counter, LFSRs, and all outputs to 0, including o_valid, o_trunc, and the error flags.
REQ-025 SHALL, if reset is asserted mid-packet, discard the packet and generate no o_valid or o_trunc afterwards; decoding resumes at the next i_data rising edge.

Structure
REQ-026 SHALL place PKT_CLKS, the header length (24), subpacket length (56), BCH polynomial 8'hC1, and the parity length (8) in the shared HDMI package, alongside the encoder's values.
REQ-027 SHALL use one sub-module, hdmibchcheck, parameterised for 1 or 2 bits per clock and instantiated 5 times: one header instance and four subpacket instances.

Verification
REQ-028 SHALL cover: encoder-generated ACR packet (header 24'h000001, subpackets {N=6144, CTS=27000}) -> o_valid at clock 32, o_header=24'h000001, o_sub0 matching the transmitted subpacket, all errors 0.
REQ-029 SHALL cover: AVI then audio infoframe back-to-back (24'h0D0282 with sub0 56'h00000000191046; 24'h0A0184 with sub0 56'h00000000001160) -> two o_valid strobes 32 clocks apart, with matching fields.
REQ-030 SHALL cover: header bit 5 flipped -> o_hdr_err=1, o_sub_err=4'b0000; i_d2[2] flipped at position 10 -> o_sub_err=4'b0100.
REQ-031 SHALL cover: i_data dropped after position 19 -> o_trunc pulse, no o_valid; the next full packet decodes cleanly.
REQ-032 SHALL cover: i_d0[3]=1 at position 0 -> o_frame_err=1, payload still correct.
REQ-033 SHALL cover: i_rst_n low for 1 clock at position 15 -> no o_valid, all outputs 0, and the next island decodes correctly.
